// File: rtl/multicycle_ctrl.sv
// Multicycle fetch/decode/execute/mem/writeback controller with handshake timeout.
// Optional define HALT_ON_RESERVED_EN: reserved class 11 halts instead of retiring as a NOP.
module multicycle_ctrl #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [7:0]  TIMEOUT_MAX = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  input  logic [1:0]  instr_class,
  input  logic        dec_mem_write,
  input  logic        dec_reg_write,
  input  logic        branch_taken,
  input  logic [15:0] jump_target,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [15:0] pc,
  output logic [2:0]  state,
  output logic        halted,
  output logic        fault,
  output logic [15:0] retire_count
);

  localparam int unsigned XLEN   = 16;
  localparam int unsigned WAIT_W = 8;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   retire_q, retire_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              fault_q, fault_d;

  logic              fetch_req, data_req, data_we, wb_we;
  logic [WAIT_W:0]   wait_inc;
  logic              timeout;

  // One more unacked cycle; timeout once the count reaches TIMEOUT_MAX.
  assign wait_inc = (WAIT_W+1)'(wait_q) + (WAIT_W+1)'(1);
  assign timeout  = wait_inc >= (WAIT_W+1)'(TIMEOUT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      retire_q <= '0;
      wait_q   <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      retire_q <= retire_d;
      wait_q   <= wait_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retire_d  = retire_q;
    wait_d    = '0;
    fault_d   = fault_q;
    fetch_req = 1'b0;
    data_req  = 1'b0;
    data_we   = 1'b0;
    wb_we     = 1'b0;

    case (state_q)
      S_FETCH: begin
        fetch_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          pc_d    = pc_q + XLEN'(1);
          state_d = S_DECODE;
        end else if (timeout) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_inc[WAIT_W-1:0];
        end
      end

      S_DECODE: state_d = S_EXECUTE;

      S_EXECUTE: begin
        case (instr_class)
          2'b00: state_d = S_MEM;
          2'b01: state_d = S_WB;
          2'b10: begin
            if (branch_taken) pc_d = jump_target;
            retire_d = retire_q + XLEN'(1);
            state_d  = S_FETCH;
          end
          default: begin
`ifdef HALT_ON_RESERVED_EN
            state_d = S_HALT;
`else
            retire_d = retire_q + XLEN'(1);
            state_d  = S_FETCH;
`endif
          end
        endcase
      end

      S_MEM: begin
        data_req = 1'b1;
        data_we  = dec_mem_write;
        if (dmem_ack) begin
          if (dec_mem_write) begin
            retire_d = retire_q + XLEN'(1);
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_inc[WAIT_W-1:0];
        end
      end

      S_WB: begin
        wb_we    = dec_reg_write;
        retire_d = retire_q + XLEN'(1);
        state_d  = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_HALT;
    endcase
  end

  // Strobes are suppressed while reset is held so in-flight requests drop at once.
  assign imem_req     = fetch_req & ~rst;
  assign dmem_req     = data_req & ~rst;
  assign dmem_we      = data_we & ~rst;
  assign rf_we        = wb_we & ~rst;
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign instr        = instr_q;
  assign retire_count = retire_q;
  assign fault        = fault_q;
  assign state        = state_q;
  assign halted       = (state_q == S_HALT);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against a procedural instruction-level model.
module tb_multicycle_ctrl;

  localparam int          TMAX = 4;
  localparam logic [15:0] RPC  = 16'h0000;
  localparam logic [2:0]  ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2, ST_M = 3'd3, ST_W = 3'd4, ST_H = 3'd5;

  logic        clk, rst;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, rf_we;
  logic [15:0] imem_addr, imem_rdata, instr, jump_target, pc, retire_count;
  logic [1:0]  instr_class;
  logic        dec_mem_write, dec_reg_write, branch_taken, halted, fault;
  logic [2:0]  state;

  multicycle_ctrl #(.RESET_PC(RPC), .TIMEOUT_MAX(8'(TMAX))) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_class(instr_class),
    .dec_mem_write(dec_mem_write), .dec_reg_write(dec_reg_write),
    .branch_taken(branch_taken), .jump_target(jump_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .pc(pc), .state(state), .halted(halted), .fault(fault),
    .retire_count(retire_count)
  );

  // Simple decoder stand-in: class in [15:14], store flag in [13].
  assign instr_class   = instr[15:14];
  assign dec_mem_write = instr[13];
  assign dec_reg_write = (instr[15:14] == 2'b01) | ((instr[15:14] == 2'b00) & ~instr[13]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 0;

  logic [15:0] m_pc, m_instr, m_ret;
  logic        m_fault, m_halt;

  logic [2:0]  exp_state;
  logic        exp_ireq, exp_dreq, exp_dwe, exp_rfwe, exp_fault, exp_halt;
  logic [15:0] exp_pc, exp_instr, exp_ret;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model's expectation for this cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", 32'(state), 32'(exp_state));
      chk("imem_req", 32'(imem_req), 32'(exp_ireq));
      if (exp_ireq) chk("imem_addr", 32'(imem_addr), 32'(exp_pc));
      chk("dmem_req", 32'(dmem_req), 32'(exp_dreq));
      chk("dmem_we", 32'(dmem_we), 32'(exp_dwe));
      chk("rf_we", 32'(rf_we), 32'(exp_rfwe));
      chk("pc", 32'(pc), 32'(exp_pc));
      chk("instr", 32'(instr), 32'(exp_instr));
      chk("retire_count", 32'(retire_count), 32'(exp_ret));
      chk("fault", 32'(fault), 32'(exp_fault));
      chk("halted", 32'(halted), 32'(exp_halt));
    end
  end

  task automatic cyc(input logic [2:0] st, input logic ir, input logic dr, input logic dw, input logic rw);
    exp_state = st; exp_ireq = ir; exp_dreq = dr; exp_dwe = dw; exp_rfwe = rw;
    exp_pc = m_pc; exp_instr = m_instr; exp_ret = m_ret; exp_fault = m_fault;
    exp_halt = (st == ST_H);
    @(posedge clk); #1;
  endtask

  // Runs one instruction through the model; abort leaves the DUT mid-MEM after one unacked cycle.
  task automatic do_instr(input logic [15:0] word, input int fw, input int mw,
                          input logic bt, input logic [15:0] tgt, input bit abort);
    logic [1:0] cls;
    logic st_w, rg_w;
    bit got;
    cls  = word[15:14];
    st_w = word[13];
    rg_w = (cls == 2'b01) || (cls == 2'b00 && !word[13]);
    got  = 0;
    for (int w = 0; w <= TMAX && !got; w++) begin
      imem_ack   = (w == fw);
      imem_rdata = (w == fw) ? word : 16'($urandom);
      cyc(ST_F, 1'b1, 1'b0, 1'b0, 1'b0);
      if (w == fw) got = 1;
      else if (w + 1 == TMAX) begin
        imem_ack = 1'b0; m_fault = 1'b1; m_halt = 1'b1;
        return;
      end
    end
    m_instr = word;
    m_pc    = m_pc + 16'd1;
    imem_ack = 1'b0;
    cyc(ST_D, 1'b0, 1'b0, 1'b0, 1'b0);
    branch_taken = bt;
    jump_target  = tgt;
    cyc(ST_E, 1'b0, 1'b0, 1'b0, 1'b0);
    branch_taken = 1'b0;
    jump_target  = 16'($urandom);
    if (cls == 2'b10) begin
      if (bt) m_pc = tgt;
      m_ret = m_ret + 16'd1;
      return;
    end
    if (cls == 2'b11) begin
`ifdef HALT_ON_RESERVED_EN
      m_halt = 1'b1;
`else
      m_ret = m_ret + 16'd1;
`endif
      return;
    end
    if (cls == 2'b00) begin
      got = 0;
      for (int w = 0; w <= TMAX && !got; w++) begin
        if (abort && w == 1) return;
        dmem_ack = (w == mw);
        cyc(ST_M, 1'b0, 1'b1, st_w, 1'b0);
        if (w == mw) got = 1;
        else if (w + 1 == TMAX) begin
          m_fault = 1'b1; m_halt = 1'b1;
          return;
        end
      end
      dmem_ack = 1'b0;
      if (st_w) begin
        m_ret = m_ret + 16'd1;
        return;
      end
    end
    cyc(ST_W, 1'b0, 1'b0, 1'b0, rg_w);
    m_ret = m_ret + 16'd1;
  endtask

  task automatic halt_cycles();
    imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (3) cyc(ST_H, 1'b0, 1'b0, 1'b0, 1'b0);
    imem_ack = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic do_reset();
    chk_en = 0;
    rst = 1'b1;
    #1;
    chk("rst_state", 32'(state), 32'(ST_F));
    chk("rst_pc", 32'(pc), 32'(RPC));
    chk("rst_instr", 32'(instr), 32'h0);
    chk("rst_retire", 32'(retire_count), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_reqs", 32'({imem_req, dmem_req, dmem_we, rf_we, halted}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_pc = RPC; m_instr = 16'h0; m_ret = 16'h0; m_fault = 1'b0; m_halt = 1'b0;
    chk_en = 1;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 16'h0;
    branch_taken = 1'b0; jump_target = 16'h0;
    m_pc = RPC; m_instr = 16'h0; m_ret = 16'h0; m_fault = 1'b0; m_halt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Zero-wait ALU instruction.
    do_instr(16'h4000, 0, 0, 1'b0, 16'h0, 0);
    chk("alu_pc", 32'(pc), 32'h1);
    chk("alu_retire", 32'(retire_count), 32'h1);

    // Load with three wait cycles, then a store.
    do_instr(16'h0000, 0, 3, 1'b0, 16'h0, 0);
    do_instr(16'h2000, 0, 0, 1'b0, 16'h0, 0);
    chk("ld_st_retire", 32'(retire_count), 32'h3);

    // Jumps across the top of the address space.
    do_instr(16'h8000, 0, 0, 1'b1, 16'hFFFF, 0);
    do_instr(16'h8000, 0, 0, 1'b1, 16'h0040, 0);
    chk("jump_taken_pc", 32'(pc), 32'h0040);
    do_instr(16'h8000, 0, 0, 1'b1, 16'hFFFF, 0);
    do_instr(16'h8000, 0, 0, 1'b0, 16'h1234, 0);
    chk("jump_wrap_pc", 32'(pc), 32'h0000);

    // Reserved class.
    do_instr(16'hC000, 0, 0, 1'b0, 16'h0, 0);
`ifdef HALT_ON_RESERVED_EN
    chk("rsv_halted", 32'(halted), 32'h1);
    chk("rsv_retire", 32'(retire_count), 32'h7);
    halt_cycles();
    do_reset();
`else
    chk("rsv_halted", 32'(halted), 32'h0);
    chk("rsv_retire", 32'(retire_count), 32'h8);
    chk("rsv_pc", 32'(pc), 32'h0001);
`endif

    // Fetch never acknowledged.
    do_instr(16'h4000, TMAX, 0, 1'b0, 16'h0, 0);
    chk("to_fault", 32'(fault), 32'h1);
    chk("to_halted", 32'(halted), 32'h1);
    chk("to_imem_req", 32'(imem_req), 32'h0);
    halt_cycles();
    do_reset();

    // Reset while a data request is outstanding.
    do_instr(16'h4000, 1, 0, 1'b0, 16'h0, 0);
    do_instr(16'h0000, 0, 3, 1'b0, 16'h0, 1);
    chk("mid_mem_dreq", 32'(dmem_req), 32'h1);
    do_reset();

    for (int i = 0; i < 300; i++) begin
      logic [15:0] word;
      int fw, mw;
      word = 16'($urandom);
      fw = ($urandom_range(0, 24) == 0) ? TMAX : int'($urandom_range(0, TMAX - 1));
      mw = ($urandom_range(0, 24) == 0) ? TMAX : int'($urandom_range(0, TMAX - 1));
      do_instr(word, fw, mw, 1'($urandom), 16'($urandom), 0);
      if (m_halt) begin
        halt_cycles();
        do_reset();
      end
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT_MAX, default 8'd255, max wait cycles on a memory handshake before fault.
REQ-003 clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 imem_req  output  1  instruction fetch request.
REQ-006 imem_addr  output  16  fetch address (equals pc).
REQ-007 imem_ack  input  1  fetch complete, imem_rdata valid this cycle.
REQ-008 imem_rdata  input  16  fetched instruction word.
REQ-009 instr  output  16  latched instruction register, feeds the decoder.
REQ-010 instr_class  input  2  decoded class: 00 mem, 01 ALU, 10 jump, 11 reserved.
REQ-011 dec_mem_write, dec_reg_write  input  1 each  decoder store / register-write flags.
REQ-012 branch_taken  input  1  comparator result for the current jump instruction.
REQ-013 jump_target  input  16  register value used as the new PC.
REQ-014 dmem_req, dmem_we  output  1 each  data memory request / write enable.
REQ-015 dmem_ack  input  1  data access complete.
REQ-016 rf_we  output  1  register-file write strobe.
REQ-017 pc  output  16  program counter.
REQ-018 state  output  3  current FSM state code.
REQ-019 halted, fault  output  1 each  halt status / handshake timeout status.
REQ-020 retire_count  output  16  count of retired instructions.

Function
REQ-021 SHALL implement states FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to HALT.
REQ-022 FETCH: SHALL assert imem_req with imem_addr=pc, held stable until imem_ack; on the ack edge SHALL latch instr<=imem_rdata, pc<=pc+1 (wraps 16'hFFFF->16'h0000), go to DECODE.
REQ-023 imem_ack in the same cycle as imem_req is legal; zero-wait fetch takes 1 cycle.
REQ-024 DECODE: one cycle, no outputs asserted, go to EXECUTE.
REQ-025 EXECUTE: class 00 -> MEM; 01 -> WB; 10 -> pc<=jump_target if branch_taken else unchanged, retire, go to FETCH; 11 -> per REQ-036.
REQ-026 MEM: dmem_req=1, dmem_we=dec_mem_write, held until dmem_ack; on ack a store retires and goes to FETCH, a load goes to WB.
REQ-027 WB: rf_we=dec_reg_write for exactly one cycle, retire, go to FETCH.
REQ-028 Latency with zero-wait memories: ALU 4 cycles, load 5, store 4, jump 3.
REQ-029 retire_count SHALL increment by 1 on every retiring transition and wrap 16'hFFFF->0.
REQ-030 A wait counter SHALL clear on entering FETCH or MEM and count each unacked cycle; reaching TIMEOUT_MAX SHALL set fault=1 and enter HALT.
REQ-031 HALT: no requests, no strobes, pc/instr/retire_count frozen; exit only by reset.
REQ-032 halted SHALL be 1 exactly when state==HALT.

Reset
REQ-033 On rst assertion, immediately and asynchronously: state=FETCH, pc=RESET_PC, instr=0, retire_count=0, fault=0, wait counter=0.
REQ-034 While rst=1: imem_req, dmem_req, dmem_we, rf_we, halted all 0; an in-flight request SHALL be dropped without retire.
REQ-035 First fetch SHALL begin on the first rising clk edge after rst deasserts.

Configuration
REQ-036 With HALT_ON_RESERVED_EN defined, class 11 in EXECUTE SHALL enter HALT without retiring; undefined, class 11 SHALL retire as a NOP and go to FETCH with pc unchanged.

Verification
REQ-037 Zero-wait imem at RESET_PC=0, ALU instr 16'h4000 -> states 0,1,2,4,0; rf_we pulse 1 cycle; pc=1; retire_count=1.
REQ-038 Load 16'h0000 with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, then WB rf_we; store 16'h2000 -> dmem_we=1, no rf_we.
REQ-039 Jump at pc=16'hFFFF, branch_taken=1, jump_target=16'h0040 -> pc=16'h0040; branch_taken=0 -> pc wraps to 16'h0000.
REQ-040 imem_ack never asserted, TIMEOUT_MAX=4 -> fault=1, halted=1 after 4 wait cycles, imem_req drops.
REQ-041 rst pulsed mid-MEM with dmem_req=1 -> dmem_req=0 same cycle, pc=RESET_PC, retire_count=0; instr 16'hC000 halts only when HALT_ON_RESERVED_EN defined.
